// File: rtl/product_accumulator.sv
// Frame accumulator: sums a length-prefixed run of multiplier products and presents
// the total with a sticky overflow flag. Build option: PRODUCT_ACCUMULATOR_DROP_OVF_EN.
module product_accumulator #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           start_in,
    input  logic [COUNT_WIDTH-1:0]         length_in,
    input  logic [2*WIDTH-1:0]             product_in,
    input  logic                           overflow_in,
    input  logic                           valid_in,
    output logic                           ready_out,
    output logic [2*WIDTH+COUNT_WIDTH-1:0] sum_out,
    output logic                           overflow_out,
    output logic                           sum_valid_out,
    input  logic                           sum_ready_in,
    output logic                           busy_out
);
    localparam int SUM_W = 2*WIDTH + COUNT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [SUM_W-1:0]       acc_reg;
    logic [COUNT_WIDTH-1:0] count_reg;
    logic                   ovf_reg;
    logic [SUM_W-1:0]       sum_out_reg;
    logic                   ovf_out_reg;

    logic                   accept;
    logic                   last_term;
    logic [SUM_W-1:0]       addend;
    logic [SUM_W-1:0]       acc_next;
    logic                   ovf_next;

    assign accept    = (state_reg == S_ACCUM) && valid_in;
    assign last_term = (count_reg == COUNT_WIDTH'(1));

`ifdef PRODUCT_ACCUMULATOR_DROP_OVF_EN
    // Flagged products still consume a term slot but contribute nothing to the sum.
    assign addend = overflow_in ? '0 : {{COUNT_WIDTH{1'b0}}, product_in};
`else
    assign addend = {{COUNT_WIDTH{1'b0}}, product_in};
`endif

    assign acc_next = acc_reg + addend;
    assign ovf_next = ovf_reg | overflow_in;

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_in) begin
                    state_next = (length_in == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && last_term) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (sum_ready_in) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode from state only
    always_comb begin
        ready_out     = 1'b0;
        sum_valid_out = 1'b0;
        busy_out      = 1'b0;
        case (state_reg)
            S_ACCUM: begin
                ready_out = 1'b1;
                busy_out  = 1'b1;
            end
            S_DONE: begin
                sum_valid_out = 1'b1;
                busy_out      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath; the result registers only change on frame start/completion, so they
    // hold stable through DONE and keep the last frame's values while IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_reg     <= '0;
            count_reg   <= '0;
            ovf_reg     <= 1'b0;
            sum_out_reg <= '0;
            ovf_out_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && start_in) begin
                acc_reg   <= '0;
                count_reg <= length_in;
                ovf_reg   <= 1'b0;
                if (length_in == '0) begin
                    sum_out_reg <= '0;
                    ovf_out_reg <= 1'b0;
                end
            end else if (accept) begin
                acc_reg   <= acc_next;
                count_reg <= count_reg - COUNT_WIDTH'(1);
                ovf_reg   <= ovf_next;
                if (last_term) begin
                    sum_out_reg <= acc_next;
                    ovf_out_reg <= ovf_next;
                end
            end
        end
    end

    assign sum_out      = sum_out_reg;
    assign overflow_out = ovf_out_reg;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: directed frames plus randomized frames
// compared against a plain-arithmetic frame-sum model.
module tb_product_accumulator;
    localparam int WIDTH       = 8;
    localparam int COUNT_WIDTH = 4;
    localparam int SUM_W       = 2*WIDTH + COUNT_WIDTH;

`ifdef PRODUCT_ACCUMULATOR_DROP_OVF_EN
    localparam bit DROP_OVF = 1'b1;
`else
    localparam bit DROP_OVF = 1'b0;
`endif

    logic                   clock;
    logic                   reset_n;
    logic                   start_in;
    logic [COUNT_WIDTH-1:0] length_in;
    logic [2*WIDTH-1:0]     product_in;
    logic                   overflow_in;
    logic                   valid_in;
    logic                   ready_out;
    logic [SUM_W-1:0]       sum_out;
    logic                   overflow_out;
    logic                   sum_valid_out;
    logic                   sum_ready_in;
    logic                   busy_out;

    int vectors     = 0;
    int miscompares = 0;

    logic [2*WIDTH-1:0] prod_q[$];
    logic               ovf_q[$];

    product_accumulator #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start_in     (start_in),
        .length_in    (length_in),
        .product_in   (product_in),
        .overflow_in  (overflow_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .sum_out      (sum_out),
        .overflow_out (overflow_out),
        .sum_valid_out(sum_valid_out),
        .sum_ready_in (sum_ready_in),
        .busy_out     (busy_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"},       64'(sum_out),       64'd0);
        check({tag, "_ovf"},       64'(overflow_out),  64'd0);
        check({tag, "_sum_valid"}, 64'(sum_valid_out), 64'd0);
        check({tag, "_ready"},     64'(ready_out),     64'd0);
        check({tag, "_busy"},      64'(busy_out),      64'd0);
    endtask

    // Runs one frame from prod_q/ovf_q; the expected result is the plain sum of the
    // terms (minus dropped ones in the drop build) and the OR of their flags.
    task automatic run_frame(input string tag, input int max_gap, input int bp_cycles,
                             output longint exp_sum, output logic exp_ovf);
        int len;
        int gap;
        len     = prod_q.size();
        exp_sum = 0;
        exp_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (!(DROP_OVF && ovf_q[i])) exp_sum += longint'(prod_q[i]);
            exp_ovf |= ovf_q[i];
        end

        start_in  = 1'b1;
        length_in = COUNT_WIDTH'(len);
        tick();
        start_in  = 1'b0;
        if (len != 0) check({tag, "_ready_after_start"}, 64'(ready_out), 64'd1);

        for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                valid_in   = 1'b0;
                start_in   = 1'b1;   // must be ignored outside IDLE
                length_in  = '0;
                product_in = 16'($urandom);
                tick();
                check({tag, "_stall_ready"}, 64'(ready_out), 64'd1);
                check({tag, "_stall_valid"}, 64'(sum_valid_out), 64'd0);
            end
            start_in    = 1'b0;
            valid_in    = 1'b1;
            product_in  = prod_q[i];
            overflow_in = ovf_q[i];
            tick();
            valid_in    = 1'b0;
            overflow_in = 1'b0;
            if (i < len - 1) check({tag, "_mid_ready"}, 64'(ready_out), 64'd1);
        end

        check({tag, "_done_valid"}, 64'(sum_valid_out), 64'd1);
        check({tag, "_done_sum"},   64'(sum_out),       64'(exp_sum));
        check({tag, "_done_ovf"},   64'(overflow_out),  64'(exp_ovf));
        check({tag, "_done_ready"}, 64'(ready_out),     64'd0);
        check({tag, "_done_busy"},  64'(busy_out),      64'd1);

        for (int b = 0; b < bp_cycles; b++) begin
            sum_ready_in = 1'b0;
            start_in     = 1'b1;
            length_in    = COUNT_WIDTH'(5);
            tick();
            check({tag, "_bp_valid"}, 64'(sum_valid_out), 64'd1);
            check({tag, "_bp_sum"},   64'(sum_out),       64'(exp_sum));
            check({tag, "_bp_ovf"},   64'(overflow_out),  64'(exp_ovf));
            check({tag, "_bp_ready"}, 64'(ready_out),     64'd0);
        end
        start_in     = 1'b0;
        sum_ready_in = 1'b1;
        tick();
        sum_ready_in = 1'b0;
        check({tag, "_idle_busy"},  64'(busy_out),      64'd0);
        check({tag, "_idle_valid"}, 64'(sum_valid_out), 64'd0);
        check({tag, "_idle_sum"},   64'(sum_out),       64'(exp_sum));
        check({tag, "_idle_ovf"},   64'(overflow_out),  64'(exp_ovf));
    endtask

    initial begin
        longint es;
        logic   eo;
        int     len;

        reset_n      = 1'b0;
        start_in     = 1'b0;
        length_in    = '0;
        product_in   = '0;
        overflow_in  = 1'b0;
        valid_in     = 1'b0;
        sum_ready_in = 1'b0;
        tick();
        tick();
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();
        check_all_zero("post_reset_idle");

        // Basic frame 10+20+30
        prod_q = '{16'd10, 16'd20, 16'd30};
        ovf_q  = '{1'b0, 1'b0, 1'b0};
        run_frame("basic", 0, 0, es, eo);
        check("basic_const_sum", 64'(sum_out), 64'd60);

        // Stalls of 3 cycles and 5 cycles of backpressure
        prod_q = '{16'h1234, 16'hABCD};
        ovf_q  = '{1'b0, 1'b0};
        run_frame("stall_bp", 3, 5, es, eo);
        check("stall_bp_const_sum", 64'(sum_out), 64'h0BE01);

        // Zero-length frame
        prod_q.delete();
        ovf_q.delete();
        run_frame("zero_len", 0, 2, es, eo);

        // Maximum frame of all-ones products
        prod_q.delete();
        ovf_q.delete();
        for (int i = 0; i < 15; i++) begin
            prod_q.push_back(16'hFFFF);
            ovf_q.push_back(1'b0);
        end
        run_frame("max_frame", 1, 1, es, eo);
        check("max_frame_const_sum", 64'(sum_out), 64'd983025);

        // Overflow flag handling
        prod_q = '{16'd100, 16'd200};
        ovf_q  = '{1'b0, 1'b1};
        run_frame("overflow", 0, 0, es, eo);
        check("overflow_const_flag", 64'(overflow_out), 64'd1);
        check("overflow_const_sum", 64'(sum_out), DROP_OVF ? 64'd100 : 64'd300);

        // Reset after one of three accepts
        start_in  = 1'b1;
        length_in = COUNT_WIDTH'(3);
        tick();
        start_in    = 1'b0;
        valid_in    = 1'b1;
        product_in  = 16'd77;
        tick();
        valid_in    = 1'b0;
        reset_n     = 1'b0;
        tick();
        reset_n     = 1'b1;
        check_all_zero("mid_reset");
        for (int i = 0; i < 4; i++) begin
            valid_in   = 1'b1;
            product_in = 16'd5;
            tick();
            check("mid_reset_no_result", 64'(sum_valid_out), 64'd0);
            check("mid_reset_no_accept", 64'(ready_out), 64'd0);
        end
        valid_in = 1'b0;
        prod_q = '{16'd7, 16'd8, 16'd9};
        ovf_q  = '{1'b0, 1'b0, 1'b0};
        run_frame("after_reset", 1, 1, es, eo);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            prod_q.delete();
            ovf_q.delete();
            len = $urandom_range(0, 15);
            for (int i = 0; i < len; i++) begin
                prod_q.push_back(16'($urandom));
                ovf_q.push_back($urandom_range(0, 3) == 0);
            end
            run_frame($sformatf("rand%0d", f), 3, $urandom_range(0, 4), es, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter WIDTH, default 8, operand width of the upstream multiplicator; product_in is 2*WIDTH bits.
REQ-002 Parameter COUNT_WIDTH, default 4, width of the term-count field; a frame holds at most 2^COUNT_WIDTH-1 terms.
REQ-003 clock  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start_in  input  1  begins a frame when sampled high in IDLE.
REQ-006 length_in  input  COUNT_WIDTH  number of products in the frame, sampled with start_in.
REQ-007 product_in  input  2*WIDTH  product from the multiplicator stage.
REQ-008 overflow_in  input  1  overflow flag accompanying product_in.
REQ-009 valid_in  input  1  product_in/overflow_in valid.
REQ-010 ready_out  output  1  block accepts a product this cycle.
REQ-011 sum_out  output  2*WIDTH+COUNT_WIDTH  accumulated frame sum.
REQ-012 overflow_out  output  1  sticky OR of overflow_in over accepted frame products.
REQ-013 sum_valid_out  output  1  sum_out/overflow_out hold a completed frame.
REQ-014 sum_ready_in  input  1  downstream accepts the result.
REQ-015 busy_out  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, ACCUM, DONE; all outputs are registered or decoded from the state only.
REQ-017 IDLE: start_in=1 and length_in!=0 -> ACCUM; the accumulator clears to 0, the count loads length_in, and the overflow flag clears.
REQ-018 IDLE: start_in=1 and length_in=0 -> DONE with sum_out=0 and overflow_out=0.
REQ-019 start_in is ignored outside IDLE.
REQ-020 ready_out=1 only in ACCUM; a product is accepted on a cycle where valid_in=1 and ready_out=1.
REQ-021 Accept: accumulator += zero-extended product_in; overflow flag |= overflow_in; count decrements by 1.
REQ-022 An accept while count=1 moves to DONE; sum_valid_out rises on the next cycle, which gives a latency of 1 cycle from the last accept.
REQ-023 valid_in=0 in ACCUM stalls the block with no state change, for any number of cycles.
REQ-024 DONE: sum_valid_out=1; sum_out and overflow_out stay stable until sum_valid_out=1 and sum_ready_in=1, then the block returns to IDLE the next cycle.
REQ-025 The accumulator width of 2*WIDTH+COUNT_WIDTH guarantees the sum never wraps, even with the maximum term count of all-ones products.
REQ-026 sum_out and overflow_out keep the last frame's values in IDLE until the next start.

Reset
REQ-027 reset_n=0 at a rising edge forces IDLE and sets the accumulator, count, overflow flag, sum_out, overflow_out, sum_valid_out, ready_out and busy_out to 0.
REQ-028 Reset mid-frame (ACCUM or DONE) abandons the frame; no partial result is presented afterwards.

Configuration
REQ-029 Macro PRODUCT_ACCUMULATOR_DROP_OVF_EN.
  - Defined: an accepted product with overflow_in=1 still counts as a term and sets the overflow flag, but it is not added to the sum.
  - Undefined: every accepted product is added regardless of overflow_in.
  - overflow_out behaviour is the same in both builds.

Verification (WIDTH=8, COUNT_WIDTH=4)
REQ-030 Basic frame: length 3, products 10, 20, 30 on consecutive cycles -> sum_out=60 and sum_valid_out=1 one cycle after the third accept; overflow_out=0.
REQ-031 Stalls and backpressure: length 2, valid_in gaps of 3 cycles, sum_ready_in low for 5 cycles in DONE -> sum_out=0x...; result held at the correct sum throughout, ready_out=0, return to IDLE one cycle after the handshake.
REQ-032 Zero length: start_in with length_in=0 -> DONE next cycle with sum_out=0 and no product accepted.
REQ-033 Maximum frame: length 15, each product 65535 -> sum_out=983025 (0xEFFF1), no wrap.
REQ-034 Overflow: length 2, product 100 (overflow_in=0) then 200 (overflow_in=1) -> overflow_out=1; sum_out=300 without the macro, 100 with PRODUCT_ACCUMULATOR_DROP_OVF_EN.
REQ-035 Reset mid-frame: reset_n=0 for one cycle after 1 of 3 accepts -> next cycle all outputs are 0 and the state is IDLE; a new frame then runs correctly.
